// File: rtl/ram_reg_file.sv
// ram_reg_file: 32x8 flip-flop register file, synchronous write, combinational read
module ram_reg_file #(
    parameter  int DATA_W = 8,
    parameter  int ADDR_W = 5,
    localparam int DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);
    logic [DEPTH-1:0]  w_sel;
    logic [DATA_W-1:0] w_rd [DEPTH];
    assign w_sel = we ? DEPTH'(1) << addr : '0;
    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
        logic [DATA_W-1:0] r_q;
        // one register per location; async clear beats any write on the same edge
        always_ff @(posedge clk or negedge rst)
            if (!rst) r_q <= '0;
            else if (w_sel[i]) r_q <= din;
        assign w_rd[i] = r_q;
    end
    assign dout = w_rd[addr];
endmodule

// File: tb/tb_ram_reg_file.sv
// tb_ram_reg_file: directed checks of reset clear, write gating, same-address timing and full sweep
`timescale 1ns/100ps
module tb_ram_reg_file;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       we = 1'b0;
    logic [4:0] addr = '0;
    logic [7:0] din = '0;
    logic [7:0] dout;
    int errs = 0;
    int checks = 0;
    logic [7:0] pre [32];

    ram_reg_file dut (.clk(clk), .rst(rst), .we(we), .addr(addr), .din(din), .dout(dout));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a; din = d; we = 1'b1;
        @(posedge clk);
        #1 we = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [7:0] exp);
        addr = a;
        #0.1 chk(tag, dout, exp);
    endtask

    initial begin
        #2;
        rd("reset_a0", 5'd0, 8'h00);
        rd("reset_a31", 5'd31, 8'h00);
        @(negedge clk) rst = 1'b1;
        for (int i = 0; i < 32; i++) begin
            pre[i] = 8'($urandom_range(1, 255));
            wr(5'(i), pre[i]);
        end
        @(negedge clk);
        rd("preload_a9", 5'd9, pre[9]);
        rd("preload_a30", 5'd30, pre[30]);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 32; i++) rd($sformatf("async_clr_a%0d", i), 5'(i), 8'h00);
        @(negedge clk) rst = 1'b1;
        wr(5'd0, 8'h01);
        wr(5'd4, 8'h02);
        @(negedge clk);
        rd("basic_a0", 5'd0, 8'h01);
        rd("basic_a4", 5'd4, 8'h02);
        rd("basic_a8", 5'd8, 8'h00);
        @(negedge clk);
        addr = 5'd5; din = 8'hAA; we = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rd("we_gate_a5", 5'd5, 8'h00);
        wr(5'd3, 8'h11);
        @(negedge clk);
        addr = 5'd3; din = 8'h22; we = 1'b1;
        #1 chk("same_addr_before", dout, 8'h11);
        @(posedge clk);
        #1 chk("same_addr_after", dout, 8'h22);
        we = 1'b0;
        for (int i = 0; i < 32; i++) wr(5'(i), 8'(i) ^ 8'hA5);
        @(negedge clk);
        for (int i = 0; i < 32; i++) rd($sformatf("sweep_up_a%0d", i), 5'(i), 8'(i) ^ 8'hA5);
        for (int i = 31; i >= 0; i--) rd($sformatf("sweep_dn_a%0d", i), 5'(i), 8'(i) ^ 8'hA5);
        @(negedge clk);
        addr = 5'd7; din = 8'hFF; we = 1'b1; rst = 1'b0;
        @(posedge clk);
        #1 chk("rst_vs_wr_during", dout, 8'h00);
        @(negedge clk);
        we = 1'b0; rst = 1'b1;
        @(posedge clk);
        #1;
        rd("rst_vs_wr_a7", 5'd7, 8'h00);
        rd("rst_vs_wr_a8", 5'd8, 8'h00);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/ram_reg_file.md
Name: ram_reg_file

Overview:
- 32 x 8 general-purpose register file (data RAM) for the PIC10F200-class core.
- Single port: synchronous write, combinational read.
- Sits between the datapath (ALU result bus, FSR/indirect address logic) and the operand mux. It supplies the file-register operand `f` and stores results when the destination is `f`.

Parameters:
- DATA_W, 8, width of each register in bits.
- ADDR_W, 5, address width in bits.
- DEPTH, 32 (2**ADDR_W), number of registers. Not independently settable.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- we  input  1  write enable, active high, sampled on the rising clk edge.
- addr  input  ADDR_W  register address, shared by read and write.
- din  input  DATA_W  write data.
- dout  output  DATA_W  read data; combinational view of mem[addr].

Behaviour:
- Storage: array mem[0..DEPTH-1] of DATA_W bits. Every location is readable and writable; the block does no special-function-register decoding.
- Reset:
  - While rst=0, every mem location is forced to 0x00 immediately, with no clock needed.
  - dout therefore reads 0x00 for every addr during reset and right after it.
  - Reset dominates: any write attempted while rst=0 is ignored.
  - Reset asserted mid-operation clears all contents asynchronously, including a location written in the same cycle.
- Write:
  - On a rising clk edge with rst=1 and we=1, mem[addr] <= din.
  - Exactly one location is updated per edge.
  - When we=0, no location changes.
- Read:
  - dout = mem[addr] continuously, with zero-cycle latency from an addr change (purely combinational mux, no output register).
  - The read port is independent of we.
- Write/read same address:
  - Before the edge, dout shows the old value.
  - After the edge, dout shows din (write-first is visible one delta after the edge).
  - There is no bypass of din to dout before the edge.
- Address range: all 5-bit values 0..31 are valid. Out-of-range conditions cannot occur and need no wrap or error handling.
- X-handling: if we is X at an edge, the model behaves as if no write occurred. Verification flags this case rather than the model.
- No handshake, no busy flag; one access per cycle.
- Implementation:
  - Reset-to-zero of all entries forces flip-flops. Do not infer block RAM.
  - Use an explicit per-location write-decode and a 32:1 read mux. A generate loop or an array is acceptable.

Test Plan:
- Reset clear: preload random data into all 32 entries, then drive rst=0 mid-cycle. Every addr 0..31 must read 0x00 immediately, before the next clk edge.
- Basic write/read:
  - After reset release, write addr=0 din=0x01 (we=1 for one cycle), then write addr=4 din=0x02.
  - Reading addr=0 gives 0x01, addr=4 gives 0x02, and untouched addr=8 gives 0x00.
- Write-enable gating: set addr=5, din=0xAA, we=0 across 3 edges. mem[5] stays 0x00.
- Same-address timing: mem[3]=0x11, then drive addr=3 din=0x22 we=1. dout is 0x11 before the edge and 0x22 after it.
- Full sweep: write mem[i]=i^0xA5 for i=0..31, then read back every location in ascending and descending order. All values must match, with no aliasing between addresses.
- Reset vs write: assert rst=0 in the same cycle as we=1, addr=7, din=0xFF. mem[7] must read 0x00 after reset releases.
